// File: rtl/spectro_frame_receiver_if.sv
// Serial frame link between the transmitter side and spectro_frame_receiver.
// master drives the serial line; slave (the receiver) returns word/frame status.
interface spectro_frame_receiver_if #(
  parameter int WORD_W = 12
);
  logic              sdata;
  logic              frame_start;
  logic [WORD_W-1:0] word_data;
  logic [3:0]        word_index;
  logic              word_valid;
  logic [WORD_W-1:0] rtc_word;
  logic              frame_done;
  logic              frame_error;
  logic              busy;
  logic [7:0]        frame_count;

  modport master (
    output sdata, frame_start,
    input  word_data, word_index, word_valid, rtc_word,
           frame_done, frame_error, busy, frame_count
  );

  modport slave (
    input  sdata, frame_start,
    output word_data, word_index, word_valid, rtc_word,
           frame_done, frame_error, busy, frame_count
  );
endinterface

// File: rtl/spectro_frame_receiver.sv
// Deserialises MSB-first frames (RTC word + channel words) and reports words,
// frame completion, aborts and a wrapping frame counter.
//
//   state | meaning
//   IDLE  | waiting for frame_start; serial line ignored
//   RECV  | shifting bits of the current frame
module spectro_frame_receiver #(
  parameter int WORD_W  = 12,
  parameter int N_WORDS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  spectro_frame_receiver_if.slave  bus
);
  localparam int BIT_W = $clog2(WORD_W);

  typedef enum logic {IDLE, RECV} state_t;

  state_t            state;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] rtc_hold;
  logic [BIT_W-1:0]  bit_cnt;
  logic [3:0]        word_cnt;
  logic [WORD_W-1:0] word_data;
  logic [3:0]        word_index;
  logic              word_valid;
  logic [WORD_W-1:0] rtc_word;
  logic              frame_done;
  logic              frame_error;
  logic [7:0]        frame_count;

  logic [WORD_W-1:0] next_word;
  logic              word_end;
  logic              frame_end;

  assign next_word = {shift_reg[WORD_W-2:0], bus.sdata};
  assign word_end  = (bit_cnt == BIT_W'(WORD_W-1));
  assign frame_end = word_end && (word_cnt == 4'(N_WORDS-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      rtc_hold    <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      word_data   <= '0;
      word_index  <= '0;
      word_valid  <= 1'b0;
      rtc_word    <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      word_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (state == IDLE) begin
        if (bus.frame_start) begin
          shift_reg <= WORD_W'(bus.sdata);
          bit_cnt   <= BIT_W'(1);
          word_cnt  <= '0;
          state     <= RECV;
        end
      end else if (bus.frame_start && !frame_end) begin
        // Early restart: the partial word is dropped and this bit opens word 0.
        frame_error <= 1'b1;
        shift_reg   <= WORD_W'(bus.sdata);
        bit_cnt     <= BIT_W'(1);
        word_cnt    <= '0;
      end else begin
        shift_reg <= next_word;
        if (word_end) begin
          word_data  <= next_word;
          word_index <= word_cnt;
          word_valid <= 1'b1;
          bit_cnt    <= '0;
          word_cnt   <= word_cnt + 4'd1;
          if (word_cnt == 4'd0)
            rtc_hold <= next_word;
          // A frame_start on the final bit is ignored: that bit belongs to the old frame.
          if (frame_end) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
            rtc_word    <= (word_cnt == 4'd0) ? next_word : rtc_hold;
            state       <= IDLE;
          end
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end
    end
  end

  assign bus.word_data   = word_data;
  assign bus.word_index  = word_index;
  assign bus.word_valid  = word_valid;
  assign bus.rtc_word    = rtc_word;
  assign bus.frame_done  = frame_done;
  assign bus.frame_error = frame_error;
  assign bus.busy        = (state == RECV);
  assign bus.frame_count = frame_count;
endmodule

// File: tb/tb_spectro_frame_receiver.sv
// Directed bench for spectro_frame_receiver: table of frames plus hand-written
// abort, reset, final-bit-restart and counter-wrap sequences.
module tb_spectro_frame_receiver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spectro_frame_receiver_if #(.WORD_W(12)) bus();

  spectro_frame_receiver #(.WORD_W(12), .N_WORDS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [11:0] rtc;
    int          mode;
    int          gap;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int n_done  = 0;
  int n_err   = 0;
  int n_orphan = 0;

  logic [11:0] q_data[$];
  logic [3:0]  q_idx[$];
  int          q_cyc[$];
  logic [11:0] q_rtc[$];
  logic [7:0]  q_fc[$];
  logic [3:0]  q_didx[$];

  function automatic logic [11:0] word_of(input vec_t v, input int k);
    if (k == 0) return v.rtc;
    case (v.mode)
      1:       return k[0] ? 12'h000 : 12'hFFF;
      2:       return k[0] ? 12'hFFF : 12'h000;
      default: return 12'(k);
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.word_valid) begin
        q_data.push_back(bus.word_data);
        q_idx.push_back(bus.word_index);
        q_cyc.push_back(cyc);
      end
      if (bus.frame_done) begin
        n_done++;
        q_rtc.push_back(bus.rtc_word);
        q_fc.push_back(bus.frame_count);
        q_didx.push_back(bus.word_index);
        if (!bus.word_valid) n_orphan++;
      end
      if (bus.frame_error) n_err++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic sd, input logic fs);
    @(negedge clk);
    bus.sdata       = sd;
    bus.frame_start = fs;
  endtask

  task automatic send_words(input vec_t v, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      logic [11:0] w;
      w = word_of(v, k);
      for (int i = 11; i >= 0; i--) drive(w[i], (k == 0) && (i == 11));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'($urandom_range(0, 1)), 1'b0);
  endtask

  function automatic void clear_queues();
    q_data.delete(); q_idx.delete(); q_cyc.delete();
    q_rtc.delete();  q_fc.delete();  q_didx.delete();
  endfunction

  initial begin
    vec_t tbl[5];
    vec_t ab, nf, c, v;
    logic [11:0] w;
    int bad, gapbad, j, base_done, base_err;

    tbl = '{'{12'hA5C, 0, 1}, '{12'hFFF, 1, 0}, '{12'h000, 2, 2},
            '{12'h123, 0, 1}, '{12'h456, 0, 3}};
    bus.sdata = 1'b0;
    bus.frame_start = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.word_data, bus.word_index, bus.word_valid, bus.rtc_word,
          bus.frame_done, bus.frame_error, bus.busy, bus.frame_count}, 64'd0);
    reset = 1'b0;
    idle(2);
    check("idle_ignores_line", {bus.busy, bus.word_valid}, 64'd0);

    // Table of frames with varying inter-frame gaps
    for (int f = 0; f < 5; f++) begin
      send_words(tbl[f], 0, 15);
      idle(tbl[f].gap);
    end
    idle(3);
    check("table_strobes", q_data.size(), 80);
    check("table_frames", q_rtc.size(), 5);
    for (int f = 0; f < 5; f++) begin
      bad = 0;
      gapbad = 0;
      for (int k = 0; k < 16; k++) begin
        j = f * 16 + k;
        if (j < q_data.size()) begin
          if (q_data[j] !== word_of(tbl[f], k) || q_idx[j] !== 4'(k)) bad++;
          if (k > 0 && q_cyc[j] - q_cyc[j-1] != 12) gapbad++;
          if (k == 0 && f > 0 && q_cyc[j] - q_cyc[j-1] != 12 + tbl[f-1].gap) gapbad++;
        end else bad++;
      end
      check($sformatf("frame%0d_words", f), bad, 0);
      check($sformatf("frame%0d_spacing", f), gapbad, 0);
      check($sformatf("frame%0d_rtc", f), q_rtc.size() > f ? 64'(q_rtc[f]) : '1, 64'(tbl[f].rtc));
      check($sformatf("frame%0d_count", f), q_fc.size() > f ? 64'(q_fc[f]) : '1, 64'(f + 1));
      check($sformatf("frame%0d_done_idx", f), q_didx.size() > f ? 64'(q_didx[f]) : '1, 64'd15);
    end
    check("table_no_error", n_err, 0);
    check("done_with_valid", n_orphan, 0);
    check("busy_after_frames", bus.busy, 0);

    // Abort: restart at bit 5 of word 3
    clear_queues();
    base_err = n_err;
    ab = '{12'h7E1, 0, 0};
    nf = '{12'h3C3, 0, 0};
    send_words(ab, 0, 2);
    w = word_of(ab, 3);
    for (int i = 11; i >= 6; i--) drive(w[i], 1'b0);
    send_words(nf, 0, 7);
    check("abort_rtc_held", bus.rtc_word, 64'h456);
    send_words(nf, 8, 15);
    idle(3);
    check("abort_error_pulses", n_err - base_err, 1);
    check("abort_strobes", q_data.size(), 19);
    bad = 0;
    for (int i = 0; i < 19; i++) begin
      if (i < q_data.size()) begin
        if (i < 3) begin
          if (q_data[i] !== word_of(ab, i) || q_idx[i] !== 4'(i)) bad++;
        end else if (q_data[i] !== word_of(nf, i - 3) || q_idx[i] !== 4'(i - 3)) bad++;
      end else bad++;
    end
    check("abort_words", bad, 0);
    check("abort_rtc_new", bus.rtc_word, 64'h3C3);
    check("abort_count", bus.frame_count, 64'd6);

    // Reset mid-frame at word 7
    v = '{12'h5A5, 0, 0};
    send_words(v, 0, 6);
    w = word_of(v, 7);
    for (int i = 11; i >= 8; i--) drive(w[i], 1'b0);
    @(negedge clk);
    base_done = n_done;
    base_err  = n_err;
    reset = 1'b1;
    #1;
    check("midframe_reset_outputs", {bus.word_data, bus.word_index, bus.word_valid, bus.rtc_word,
          bus.frame_done, bus.frame_error, bus.busy, bus.frame_count}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    check("reset_no_done", n_done - base_done, 0);
    check("reset_no_error", n_err - base_err, 0);
    clear_queues();
    v = '{12'h0F0, 0, 0};
    send_words(v, 0, 15);
    idle(2);
    check("post_reset_rtc", bus.rtc_word, 64'h0F0);
    check("post_reset_count", bus.frame_count, 64'd1);
    check("post_reset_strobes", q_data.size(), 16);

    // frame_start coinciding with the final bit of a frame
    base_err = n_err;
    c = '{12'h2D2, 0, 0};
    send_words(c, 0, 14);
    w = word_of(c, 15);
    for (int i = 11; i >= 1; i--) drive(w[i], 1'b0);
    drive(w[0], 1'b1);
    drive(1'b0, 1'b0);
    idle(1);
    check("final_bit_start_no_error", n_err - base_err, 0);
    check("final_bit_start_idle", bus.busy, 0);
    check("final_bit_start_rtc", bus.rtc_word, 64'h2D2);
    check("final_bit_start_count", bus.frame_count, 64'd2);
    check("final_bit_start_last", q_data.size() > 0 ? 64'(q_data[$]) : '1, 64'h00F);

    // 254 more frames, gapless, boundary patterns: counter wraps to 0
    clear_queues();
    base_done = n_done;
    for (int f = 0; f < 254; f++) begin
      v = '{12'(f * 7), (f % 2) + 1, 0};
      send_words(v, 0, 15);
    end
    idle(3);
    check("wrap_done_count", n_done - base_done, 254);
    check("wrap_strobes", q_data.size(), 254 * 16);
    bad = 0;
    for (int f = 0; f < 254; f++) begin
      v = '{12'(f * 7), (f % 2) + 1, 0};
      for (int k = 0; k < 16; k++) begin
        j = f * 16 + k;
        if (j >= q_data.size() || q_data[j] !== word_of(v, k) || q_idx[j] !== 4'(k)) bad++;
      end
    end
    check("wrap_words", bad, 0);
    check("wrap_count_255", q_fc.size() > 252 ? 64'(q_fc[252]) : '1, 64'd255);
    check("wrap_count_0", bus.frame_count, 64'd0);
    check("wrap_rtc", bus.rtc_word, 64'(12'(253 * 7)));
    check("wrap_no_error", n_err - base_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
